// File: rtl/apb_uart_core.sv
// APB3 slave UART: TX FIFO, RX holding register, programmable baud divisor,
// optional parity and sticky error flags with a level interrupt.
module apb_uart_core #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 16,
    parameter int ADDR_W      = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              Tx,
    input  logic              RX,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = 4;

    localparam logic [2:0] A_TXDATA = 3'd0;
    localparam logic [2:0] A_RXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_BAUD   = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Value of the parity bit that makes the frame even (odd=0) or odd (odd=1).
    function automatic logic parity_f(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // ---------------- APB decode ----------------
    logic       access_s, wr_s, rd_s;
    logic [2:0] addr_s;
    logic       unused_s;

    assign access_s = PSELx & PENABLE;
    assign wr_s     = access_s & PWRITE;
    assign rd_s     = access_s & ~PWRITE;
    assign addr_s   = PADDR[4:2];
    assign unused_s = ^{PADDR, PWDATA};

    // ---------------- Registers and flags ----------------
    logic [DIV_W-1:0]     baud_r, div_eff_s, rx_half_s;
    logic                 par_en_r, par_odd_r;
    logic [DATA_BITS-1:0] rx_hold_r;
    logic                 rx_valid_r, overrun_r, perr_r, ferr_r, irq_r, tx_r;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]        tx_count_r;
    logic                 tx_full_s, tx_empty_s, push_s, pop_s;
    logic [DATA_BITS-1:0] fifo_head_s;

    assign tx_full_s   = (tx_count_r == CW'(FIFO_DEPTH));
    assign tx_empty_s  = (tx_count_r == {CW{1'b0}});
    assign push_s      = wr_s & (addr_s == A_TXDATA) & ~tx_full_s;
    assign fifo_head_s = fifo_mem_r[rd_ptr_r];

    // FIFO storage, written on an accepted push.
    always_ff @(posedge PCLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= PWDATA[DATA_BITS-1:0];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            tx_count_r <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push_s, pop_s})
                2'b10:   tx_count_r <= tx_count_r + CW'(1'b1);
                2'b01:   tx_count_r <= tx_count_r - CW'(1'b1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Effective divisor (0 behaves as 1) and mid-bit offset for RX.
    always_comb begin
        div_eff_s = baud_r;
        rx_half_s = baud_r >> 1;
        if (baud_r == {DIV_W{1'b0}}) begin
            div_eff_s = DIV_W'(1'b1);
        end else begin
            div_eff_s = baud_r;
        end
        if ((div_eff_s >> 1) == {DIV_W{1'b0}}) begin
            rx_half_s = DIV_W'(1'b1);
        end else begin
            rx_half_s = div_eff_s >> 1;
        end
    end

    // ---------------- TX FSM ----------------
    uart_state_e          tx_state_r, tx_state_s;
    logic [DIV_W-1:0]     tx_cnt_r, tx_cnt_s, tx_div_r;
    logic [BW-1:0]        tx_bit_r, tx_bit_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic                 tx_par_r, tx_pen_r, tx_load_s, tx_tick_s, tx_line_s;

    assign tx_tick_s = (tx_cnt_r == tx_div_r - DIV_W'(1'b1));
    assign pop_s     = tx_load_s;

    // TX next state; the line level is derived from the next state so Tx is a flop.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + DIV_W'(1'b1);
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_load_s  = 1'b0;
        tx_line_s  = 1'b1;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_s = {DIV_W{1'b0}};
                if (!tx_empty_s) begin
                    tx_state_s = ST_START;
                    tx_load_s  = 1'b1;
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_tick_s) begin
                    tx_state_s = ST_DATA;
                    tx_cnt_s   = {DIV_W{1'b0}};
                    tx_bit_s   = {BW{1'b0}};
                end else begin
                    tx_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tx_tick_s) begin
                    tx_cnt_s = {DIV_W{1'b0}};
                    if (tx_bit_r == BW'(DATA_BITS - 1)) begin
                        tx_state_s = tx_pen_r ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_bit_s   = tx_bit_r + BW'(1'b1);
                        tx_shift_s = tx_shift_r >> 1;
                    end
                end else begin
                    tx_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tx_tick_s) begin
                    tx_state_s = ST_STOP;
                    tx_cnt_s   = {DIV_W{1'b0}};
                end else begin
                    tx_state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tx_tick_s) begin
                    tx_cnt_s = {DIV_W{1'b0}};
                    if (!tx_empty_s) begin
                        tx_state_s = ST_START;
                        tx_load_s  = 1'b1;
                    end else begin
                        tx_state_s = ST_IDLE;
                    end
                end else begin
                    tx_state_s = ST_STOP;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_cnt_s   = {DIV_W{1'b0}};
            end
        endcase
        if (tx_load_s) begin
            tx_shift_s = fifo_head_s;
            tx_cnt_s   = {DIV_W{1'b0}};
        end else begin
            tx_shift_s = tx_shift_s;
        end
        case (tx_state_s)
            ST_START:  tx_line_s = 1'b0;
            ST_DATA:   tx_line_s = tx_shift_s[0];
            ST_PARITY: tx_line_s = tx_par_r;
            default:   tx_line_s = 1'b1;
        endcase
    end

    // TX state register; divisor and parity setup are frozen for the whole frame.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= {DIV_W{1'b0}};
            tx_div_r   <= DIV_W'(1'b1);
            tx_bit_r   <= {BW{1'b0}};
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_par_r   <= 1'b0;
            tx_pen_r   <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_r       <= tx_line_s;
            if (tx_load_s) begin
                tx_div_r <= div_eff_s;
                tx_pen_r <= par_en_r;
                tx_par_r <= parity_f(fifo_head_s, par_odd_r);
            end
        end
    end

    // ---------------- RX path ----------------
    logic                 rx_meta_r, rx_sync_r, rx_prev_r;
    uart_state_e          rx_state_r, rx_state_s;
    logic [DIV_W-1:0]     rx_cnt_r, rx_cnt_s, rx_div_r, rx_half_r;
    logic [BW-1:0]        rx_bit_r, rx_bit_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
    logic                 rx_pen_r, rx_podd_r, rx_perr_r, rx_perr_s;
    logic                 rx_start_s, rx_deliver_s, rx_ferr_s, rx_tick_s;

    assign rx_tick_s = (rx_cnt_r == rx_div_r - DIV_W'(1'b1));

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next state: start bit checked mid-bit, later bits every divisor period.
    always_comb begin
        rx_state_s   = rx_state_r;
        rx_cnt_s     = rx_cnt_r + DIV_W'(1'b1);
        rx_bit_s     = rx_bit_r;
        rx_shift_s   = rx_shift_r;
        rx_perr_s    = rx_perr_r;
        rx_start_s   = 1'b0;
        rx_deliver_s = 1'b0;
        rx_ferr_s    = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s = {DIV_W{1'b0}};
                if (rx_prev_r & ~rx_sync_r) begin
                    rx_state_s = ST_START;
                    rx_start_s = 1'b1;
                    rx_perr_s  = 1'b0;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == rx_half_r - DIV_W'(1'b1)) begin
                    rx_cnt_s   = {DIV_W{1'b0}};
                    rx_bit_s   = {BW{1'b0}};
                    rx_state_s = rx_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    rx_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (rx_tick_s) begin
                    rx_cnt_s   = {DIV_W{1'b0}};
                    rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == BW'(DATA_BITS - 1)) begin
                        rx_state_s = rx_pen_r ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + BW'(1'b1);
                    end
                end else begin
                    rx_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (rx_tick_s) begin
                    rx_cnt_s   = {DIV_W{1'b0}};
                    rx_perr_s  = (rx_sync_r != parity_f(rx_shift_r, rx_podd_r));
                    rx_state_s = ST_STOP;
                end else begin
                    rx_state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (rx_tick_s) begin
                    rx_cnt_s     = {DIV_W{1'b0}};
                    rx_deliver_s = 1'b1;
                    rx_ferr_s    = ~rx_sync_r;
                    rx_state_s   = ST_IDLE;
                end else begin
                    rx_state_s = ST_STOP;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_cnt_s   = {DIV_W{1'b0}};
            end
        endcase
    end

    // RX state register; frame settings latched on the detected falling edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= {DIV_W{1'b0}};
            rx_div_r   <= DIV_W'(1'b1);
            rx_half_r  <= DIV_W'(1'b1);
            rx_bit_r   <= {BW{1'b0}};
            rx_shift_r <= {DATA_BITS{1'b0}};
            rx_pen_r   <= 1'b0;
            rx_podd_r  <= 1'b0;
            rx_perr_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_perr_r  <= rx_perr_s;
            if (rx_start_s) begin
                rx_div_r  <= div_eff_s;
                rx_half_r <= rx_half_s;
                rx_pen_r  <= par_en_r;
                rx_podd_r <= par_odd_r;
            end
        end
    end

    // ---------------- Control/status registers ----------------
    logic rx_read_s, rx_load_s, set_ovr_s, clr_wr_s;

    assign rx_read_s = rd_s & (addr_s == A_RXDATA) & rx_valid_r;
    // A read in the delivery cycle frees the holder, so the new byte is taken.
    assign rx_load_s = rx_deliver_s & (~rx_valid_r | rx_read_s);
    assign set_ovr_s = rx_deliver_s & rx_valid_r & ~rx_read_s;
    assign clr_wr_s  = wr_s & (addr_s == A_STATUS);

    // Configuration registers, RX holding register and sticky flags.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            baud_r     <= DIV_W'(DEFAULT_DIV);
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            rx_hold_r  <= {DATA_BITS{1'b0}};
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (wr_s && addr_s == A_BAUD) baud_r <= PWDATA[DIV_W-1:0];
            if (wr_s && addr_s == A_CTRL) begin
                par_en_r  <= PWDATA[0];
                par_odd_r <= PWDATA[1];
            end
            if (rx_load_s) begin
                rx_hold_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_read_s) begin
                rx_valid_r <= 1'b0;
            end
            overrun_r <= (overrun_r & ~(clr_wr_s & PWDATA[4])) | set_ovr_s;
            perr_r    <= (perr_r & ~(clr_wr_s & PWDATA[5])) | (rx_deliver_s & rx_perr_r);
            ferr_r    <= (ferr_r & ~(clr_wr_s & PWDATA[6])) | rx_ferr_s;
            irq_r     <= rx_valid_r | overrun_r | perr_r | ferr_r;
        end
    end

    // APB read mux and error response, both qualified by the access phase.
    always_comb begin
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
        if (access_s) begin
            case (addr_s)
                A_TXDATA: PSLVERR = PWRITE & tx_full_s;
                A_RXDATA: begin
                    if (!PWRITE) begin
                        PSLVERR = ~rx_valid_r;
                        PRDATA  = rx_valid_r ? 32'(rx_hold_r) : 32'h0;
                    end else begin
                        PSLVERR = 1'b0;
                    end
                end
                A_STATUS: begin
                    if (!PWRITE) begin
                        PRDATA = {25'h0, ferr_r, perr_r, overrun_r, rx_valid_r,
                                  (tx_state_r != ST_IDLE), tx_empty_s, tx_full_s};
                    end else begin
                        PRDATA = 32'h0;
                    end
                end
                A_BAUD:   PRDATA = PWRITE ? 32'h0 : 32'(baud_r);
                A_CTRL:   PRDATA = PWRITE ? 32'h0 : {30'h0, par_odd_r, par_en_r};
                default:  PSLVERR = 1'b1;
            endcase
        end else begin
            PRDATA = 32'h0;
        end
    end

    assign PREADY = access_s;
    assign Tx     = tx_r;
    assign irq    = irq_r;

endmodule
